data_mem_responder: RTL and testbench

Data-memory responder serving the CPU core's load/store port: LW, LB, SW and SB. It accepts single-cycle request pulses and holds the request fields internally. Each access completes after a programmable wait latency, followed by a one-cycle acknowledge carrying read data or an error flag. It replaces the combinational RAM on the data side, so the core can be moved to a multi-cycle memory handshake.

---
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's load/store port (LW, LB, SW, SB).
// A request is accepted in IDLE and its fields are latched. The FSM then
// spends LATENCY+1 edges in WAIT; the access happens on the last of them,
// and Ack is raised for one cycle in RESP.
// The wait counter is loaded with LATENCY and counts down once per WAIT edge.
// The access fires on the WAIT edge where the counter is already zero, so Ack
// rises on the (LATENCY+1)th edge after acceptance. LATENCY=0 therefore spends
// a single edge in WAIT, which keeps the latency formula uniform.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Req,
    input  logic        Write,
    input  logic        Size,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Busy,
    output logic        Ack,
    output logic [31:0] RData,
    output logic        Err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    localparam int          IdxW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ByteLimit = 33'(DEPTH_WORDS) * 33'd4;

    stateT             state, nextState;
    logic [3:0]        waitCnt;
    logic [31:0]       latAddr;
    logic [31:0]       latWData;
    logic              latWrite;
    logic              latSize;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              accessNow;
    logic              accessOk;
    logic [IdxW-1:0]   wordIdx;
    logic [1:0]        lane;
    logic [31:0]       memWord;
    logic [7:0]        loadByte;
    logic [31:0]       loadData;
    logic [31:0]       storeWord;
    logic [3:0]        laneWe;

    assign Busy = (state != IDLE);
    assign Ack  = (state == RESP);

    // Address decode and load-data formatting from the latched request.
    assign wordIdx   = latAddr[IdxW+1:2];
    assign lane      = latAddr[1:0];
    assign accessNow = (state == WAIT) && (waitCnt == 4'd0);
    assign accessOk  = ({1'b0, latAddr} < ByteLimit) && !(latSize && (lane != 2'b00));
    assign memWord   = mem[wordIdx];
    assign loadByte  = memWord[8*lane +: 8];
    assign loadData  = latSize ? memWord : {{24{loadByte[7]}}, loadByte};
    assign storeWord = latSize ? latWData : {4{latWData[7:0]}};

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Req) nextState = WAIT;
            WAIT:    if (waitCnt == 4'd0) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Byte-lane write enables; only a successful store on the access edge writes.
    always_comb begin
        laneWe = 4'b0000;
        if (accessNow && accessOk && latWrite) begin
            laneWe = latSize ? 4'b1111 : (4'b0001 << lane);
        end
    end

    // Request latch, wait counter and response registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            waitCnt  <= 4'd0;
            latAddr  <= 32'd0;
            latWData <= 32'd0;
            latWrite <= 1'b0;
            latSize  <= 1'b0;
            RData    <= 32'd0;
            Err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Req) begin
                        latAddr  <= Addr;
                        latWData <= WData;
                        latWrite <= Write;
                        latSize  <= Size;
                        waitCnt  <= 4'(LATENCY);
                    end
                end
                WAIT: begin
                    if (waitCnt != 4'd0) begin
                        waitCnt <= waitCnt - 4'd1;
                    end else begin
                        Err   <= !accessOk;
                        RData <= (accessOk && !latWrite) ? loadData : 32'd0;
                    end
                end
                RESP: begin
                    RData <= 32'd0;
                    Err   <= 1'b0;
                end
                default: begin
                    RData <= 32'd0;
                    Err   <= 1'b0;
                end
            endcase
        end
    end

    // Storage array with per-byte-lane writes.
    // NOTE: the memory array has no reset; an aborted access never writes because
    // laneWe depends on the state register, which resets asynchronously.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (laneWe[i]) begin
                mem[wordIdx][8*i +: 8] <= storeWord[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed load/store scenarios
// plus randomized traffic compared against a byte-addressed reference memory.
module tb_data_mem_responder;

    localparam int DEPTH_WORDS = 256;
    localparam int LATENCY     = 2;
    localparam int MEM_BYTES   = DEPTH_WORDS * 4;
    localparam int ACK_BUDGET  = 40;

    logic        Clk;
    logic        Rst_n;
    logic        Req;
    logic        Write;
    logic        Size;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        Busy;
    logic        Ack;
    logic [31:0] RData;
    logic        Err;

    int nChecks;
    int nFails;

    logic [7:0] refMem [MEM_BYTES];

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .LATENCY    (LATENCY)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .Req  (Req),
        .Write(Write),
        .Size (Size),
        .Addr (Addr),
        .WData(WData),
        .Busy (Busy),
        .Ack  (Ack),
        .RData(RData),
        .Err  (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: byte-addressed little-endian memory.
    function automatic logic refErr(input logic s, input logic [31:0] a);
        return (a >= 32'(MEM_BYTES)) || (s && (a % 4 != 0));
    endfunction

    function automatic logic [31:0] refRead(input logic s, input logic [31:0] a);
        logic [7:0] b;
        if (refErr(s, a)) return 32'd0;
        if (s) return {refMem[a + 3], refMem[a + 2], refMem[a + 1], refMem[a]};
        b = refMem[a];
        return {{24{b[7]}}, b};
    endfunction

    task automatic refWrite(input logic s, input logic [31:0] a, input logic [31:0] d);
        if (refErr(s, a)) return;
        if (s) begin
            for (int i = 0; i < 4; i++) refMem[a + i] = d[8*i +: 8];
        end else begin
            refMem[a] = d[7:0];
        end
    endtask

    task automatic scramble();
        Write = 1'($urandom);
        Size  = 1'($urandom);
        Addr  = $urandom;
        WData = $urandom;
    endtask

    // Issues one request and waits (bounded) for its Ack; fields are scrambled while busy.
    task automatic doAccess(input logic w, input logic s, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic er, output int lat, output logic gotAck);
        @(negedge Clk);
        Req = 1'b1; Write = w; Size = s; Addr = a; WData = d;
        @(posedge Clk);
        gotAck = 1'b0; lat = 0; rd = 32'd0; er = 1'b0;
        for (int n = 0; n < ACK_BUDGET; n++) begin
            @(negedge Clk);
            Req = 1'b0;
            scramble();
            if (n == 0) check("busy_after_accept", 32'(Busy), 32'd1);
            if (Ack) begin
                gotAck = 1'b1; lat = n; rd = RData; er = Err;
                break;
            end
        end
        @(negedge Clk);
        check("ack_one_cycle", 32'(Ack), 32'd0);
        check("busy_released", 32'(Busy), 32'd0);
        check("rdata_cleared", RData, 32'd0);
    endtask

    task automatic runOp(input string tag, input logic w, input logic s, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic er);
        logic [31:0] expRd;
        logic        expErr;
        int          lat;
        logic        gotAck;
        expErr = refErr(s, a);
        expRd  = w ? 32'd0 : refRead(s, a);
        doAccess(w, s, a, d, rd, er, lat, gotAck);
        check({tag, "_ack_seen"}, 32'(gotAck), 32'd1);
        if (gotAck) begin
            check({tag, "_latency"}, 32'(lat), 32'(LATENCY + 1));
            check({tag, "_rdata"}, rd, expRd);
            check({tag, "_err"}, 32'(er), 32'(expErr));
        end
        if (w) refWrite(s, a, d);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          ackCount;
        logic [31:0] a;
        logic        w, s;

        nChecks = 0;
        nFails  = 0;
        Rst_n = 1'b0; Req = 1'b0; Write = 1'b0; Size = 1'b0; Addr = 32'd0; WData = 32'd0;
        repeat (3) @(negedge Clk);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_ack", 32'(Ack), 32'd0);
        check("reset_rdata", RData, 32'd0);
        check("reset_err", 32'(Err), 32'd0);
        Rst_n = 1'b1;

        // Give every word a known value so random loads are well defined.
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            runOp("init", 1'b1, 1'b1, 32'(i * 4), $urandom, rd, er);
        end

        // 1: word store then word load.
        runOp("t1_sw", 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, rd, er);
        runOp("t1_lw", 1'b0, 1'b1, 32'h10, 32'h0, rd, er);
        check("t1_lw_value", rd, 32'hDEADBEEF);

        // 2: byte store and sign-extended byte loads.
        runOp("t2_sb", 1'b1, 1'b0, 32'h11, 32'h80, rd, er);
        runOp("t2_lw", 1'b0, 1'b1, 32'h10, 32'h0, rd, er);
        check("t2_lw_value", rd, 32'hDEAD80EF);
        runOp("t2_lb11", 1'b0, 1'b0, 32'h11, 32'h0, rd, er);
        check("t2_lb11_value", rd, 32'hFFFFFF80);
        runOp("t2_lb10", 1'b0, 1'b0, 32'h10, 32'h0, rd, er);
        check("t2_lb10_value", rd, 32'hFFFFFFEF);
        runOp("t2_lb12", 1'b0, 1'b0, 32'h12, 32'h0, rd, er);
        check("t2_lb12_value", rd, 32'hFFFFFFAD);

        // 3: misaligned word accesses fault without writing.
        runOp("t3_lw_mis", 1'b0, 1'b1, 32'h12, 32'h0, rd, er);
        check("t3_lw_mis_err", 32'(er), 32'd1);
        runOp("t3_sw_mis", 1'b1, 1'b1, 32'h13, 32'h1, rd, er);
        check("t3_sw_mis_err", 32'(er), 32'd1);
        runOp("t3_lw", 1'b0, 1'b1, 32'h10, 32'h0, rd, er);
        check("t3_lw_value", rd, 32'hDEAD80EF);

        // 4: range boundary.
        runOp("t4_lw_oor", 1'b0, 1'b1, 32'h400, 32'h0, rd, er);
        check("t4_lw_oor_err", 32'(er), 32'd1);
        runOp("t4_sb_last", 1'b1, 1'b0, 32'h3FF, 32'hA5, rd, er);
        check("t4_sb_last_err", 32'(er), 32'd0);
        runOp("t4_lw_last", 1'b0, 1'b1, 32'h3FC, 32'h0, rd, er);
        check("t4_top_byte", 32'(rd[31:24]), 32'hA5);

        // 5: a Req pulse while busy is ignored.
        runOp("t5_sw0", 1'b1, 1'b1, 32'h24, 32'h0, rd, er);
        @(negedge Clk);
        Req = 1'b1; Write = 1'b1; Size = 1'b1; Addr = 32'h20; WData = 32'h11111111;
        @(posedge Clk);
        ackCount = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge Clk);
            if (n == 1) begin
                Req = 1'b1; Write = 1'b1; Size = 1'b1; Addr = 32'h24; WData = 32'h22222222;
            end else begin
                Req = 1'b0;
            end
            if (Ack) ackCount++;
        end
        check("t5_single_ack", 32'(ackCount), 32'd1);
        refWrite(1'b1, 32'h20, 32'h11111111);
        runOp("t5_lw24", 1'b0, 1'b1, 32'h24, 32'h0, rd, er);
        check("t5_lw24_value", rd, 32'h0);
        runOp("t5_lw20", 1'b0, 1'b1, 32'h20, 32'h0, rd, er);
        check("t5_lw20_value", rd, 32'h11111111);

        // Req held during the Ack cycle is not accepted.
        @(negedge Clk);
        Req = 1'b1; Write = 1'b1; Size = 1'b1; Addr = 32'h28; WData = 32'h33333333;
        @(posedge Clk);
        ackCount = 0;
        for (int n = 0; n < ACK_BUDGET; n++) begin
            @(negedge Clk);
            Req = 1'b0;
            if (Ack) begin
                ackCount++;
                Req = 1'b1; Write = 1'b1; Size = 1'b1; Addr = 32'h28; WData = 32'h44444444;
                break;
            end
        end
        check("ackreq_ack_seen", 32'(ackCount), 32'd1);
        @(negedge Clk);
        Req = 1'b0;
        check("ackreq_not_accepted", 32'(Busy), 32'd0);
        refWrite(1'b1, 32'h28, 32'h33333333);
        runOp("ackreq_lw", 1'b0, 1'b1, 32'h28, 32'h0, rd, er);
        check("ackreq_lw_value", rd, 32'h33333333);

        // 6: reset during WAIT aborts the store.
        runOp("t6_sw0", 1'b1, 1'b1, 32'h20, 32'h0, rd, er);
        @(negedge Clk);
        Req = 1'b1; Write = 1'b1; Size = 1'b1; Addr = 32'h20; WData = 32'h12345678;
        @(posedge Clk);
        @(negedge Clk);
        Req = 1'b0;
        check("t6_busy_before_rst", 32'(Busy), 32'd1);
        Rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(Busy), 32'd0);
        check("t6_rst_ack", 32'(Ack), 32'd0);
        check("t6_rst_rdata", RData, 32'd0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        ackCount = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge Clk);
            if (Ack) ackCount++;
        end
        check("t6_no_ack", 32'(ackCount), 32'd0);
        runOp("t6_lw", 1'b0, 1'b1, 32'h20, 32'h0, rd, er);
        check("t6_lw_value", rd, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'(MEM_BYTES) + $urandom_range(0, 4095);
                1:       a = $urandom;
                default: a = $urandom_range(0, MEM_BYTES - 1);
            endcase
            w = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            if (s && ($urandom_range(0, 3) != 0)) a[1:0] = 2'b00;
            runOp("rnd", w, s, a, $urandom, rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
